// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle. STALL_CYCLES exists only when
// HAZARD_SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
   parameter int LAT_W = 5
);
   logic             ID_ISSUE;
   logic [1:0]       ID_REG_TYPE;
   logic [4:0]       ID_ADDR1;
   logic [4:0]       ID_ADDR2;
   logic [4:0]       ID_ADDR3;
   logic             ID_WRITE_EN;
   logic             ID_F_WRITE_EN;
   logic [4:0]       ID_DEST_ADDR;
   logic [LAT_W-1:0] ID_LATENCY;
   logic             STALL;
   logic [3:0]       BUSY_COUNT;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0]      STALL_CYCLES;

   modport master (
      output ID_ISSUE, ID_REG_TYPE, ID_ADDR1, ID_ADDR2, ID_ADDR3,
             ID_WRITE_EN, ID_F_WRITE_EN, ID_DEST_ADDR, ID_LATENCY,
      input  STALL, BUSY_COUNT, STALL_CYCLES
   );
   modport slave (
      input  ID_ISSUE, ID_REG_TYPE, ID_ADDR1, ID_ADDR2, ID_ADDR3,
             ID_WRITE_EN, ID_F_WRITE_EN, ID_DEST_ADDR, ID_LATENCY,
      output STALL, BUSY_COUNT, STALL_CYCLES
   );
`else
   modport master (
      output ID_ISSUE, ID_REG_TYPE, ID_ADDR1, ID_ADDR2, ID_ADDR3,
             ID_WRITE_EN, ID_F_WRITE_EN, ID_DEST_ADDR, ID_LATENCY,
      input  STALL, BUSY_COUNT
   );
   modport slave (
      input  ID_ISSUE, ID_REG_TYPE, ID_ADDR1, ID_ADDR2, ID_ADDR3,
             ID_WRITE_EN, ID_F_WRITE_EN, ID_DEST_ADDR, ID_LATENCY,
      output STALL, BUSY_COUNT
   );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight long-latency write tracker that stalls ID until all sources are forwardable.
// Optional HAZARD_SCOREBOARD_STATS_EN adds a saturating STALL_CYCLES counter.

module hazard_scoreboard_entry #(
   parameter int LAT_W = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             alloc,
   input  logic             alloc_float,
   input  logic [4:0]       alloc_addr,
   input  logic [LAT_W-1:0] alloc_lat,
   input  logic [1:0]       reg_type,
   input  logic [4:0]       addr1,
   input  logic [4:0]       addr2,
   input  logic [4:0]       addr3,
   output logic             valid,
   output logic             src_hit,
   output logic             waw_hit
);
   logic             is_float;
   logic [4:0]       addr;
   logic [LAT_W-1:0] remain;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid    <= 1'b0;
         is_float <= 1'b0;
         addr     <= '0;
         remain   <= '0;
      end else if (alloc) begin
         valid    <= 1'b1;
         is_float <= alloc_float;
         addr     <= alloc_addr;
         remain   <= alloc_lat;
      end else if (valid) begin
         remain <= remain - 1'b1;
         if (remain == LAT_W'(1)) valid <= 1'b0;
      end
   end

   // op2 is float for any non-zero type; op3 only exists for the 3-source float form
   assign src_hit = valid &&
                    ((addr == addr1 && is_float == reg_type[1]) ||
                     (addr == addr2 && is_float == (reg_type != 2'b00)) ||
                     (reg_type == 2'b11 && is_float && addr == addr3));

   assign waw_hit = valid && addr == alloc_addr && is_float == alloc_float;
endmodule

module hazard_scoreboard #(
   parameter int ENTRIES = 4,
   parameter int LAT_W   = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   hazard_scoreboard_if.slave bus
);
   logic [ENTRIES-1:0] valid_v;
   logic [ENTRIES-1:0] src_v;
   logic [ENTRIES-1:0] waw_v;
   logic [ENTRIES-1:0] free_v;
   logic [ENTRIES-1:0] alloc_v;
   logic               alloc_req;
   logic               full;
   logic               stall;
   logic [3:0]         busy;

   // int x0 is never tracked; float f0 is an ordinary register
   assign alloc_req = bus.ID_ISSUE &&
                      (bus.ID_WRITE_EN || bus.ID_F_WRITE_EN) &&
                      (bus.ID_LATENCY != '0) &&
                      (bus.ID_F_WRITE_EN || bus.ID_DEST_ADDR != 5'd0);

   assign full   = &valid_v;
   assign free_v = ~valid_v;

   assign stall = !RESET && bus.ID_ISSUE &&
                  ((|src_v) || (alloc_req && ((|waw_v) || full)));

   // lowest-index free slot; a slot freeing this cycle still reads as busy
   assign alloc_v = (alloc_req && !stall) ? (free_v & (~free_v + 1'b1)) : '0;

   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      hazard_scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
         .CLK         (CLK),
         .RESET       (RESET),
         .alloc       (alloc_v[i]),
         .alloc_float (bus.ID_F_WRITE_EN),
         .alloc_addr  (bus.ID_DEST_ADDR),
         .alloc_lat   (bus.ID_LATENCY),
         .reg_type    (bus.ID_REG_TYPE),
         .addr1       (bus.ID_ADDR1),
         .addr2       (bus.ID_ADDR2),
         .addr3       (bus.ID_ADDR3),
         .valid       (valid_v[i]),
         .src_hit     (src_v[i]),
         .waw_hit     (waw_v[i])
      );
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < ENTRIES; i++) busy = busy + {3'b000, valid_v[i]};
   end

   assign bus.STALL      = stall;
   assign bus.BUSY_COUNT = busy;

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                                 stall_cycles <= '0;
      else if (stall && stall_cycles != '1)      stall_cycles <= stall_cycles + 32'd1;
   end

   assign bus.STALL_CYCLES = stall_cycles;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against an expiry-time model.
module tb_hazard_scoreboard;
   localparam int ENTRIES = 4;
   localparam int LAT_W   = 5;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   hazard_scoreboard_if #(.LAT_W(LAT_W)) bus ();

   hazard_scoreboard #(.ENTRIES(ENTRIES), .LAT_W(LAT_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   typedef struct {
      logic       f;
      logic [4:0] addr;
      int         expire;   // last cycle in which the write is still pending
   } pend_t;

   pend_t       q[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          peak = 0;
   longint      stat_m = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_eval(output logic st, output logic al);
      logic hit, waw, req;
      hit = 1'b0; waw = 1'b0;
      req = bus.ID_ISSUE && (bus.ID_WRITE_EN || bus.ID_F_WRITE_EN) &&
            bus.ID_LATENCY != 0 && (bus.ID_F_WRITE_EN || bus.ID_DEST_ADDR != 0);
      foreach (q[i]) begin
         if (q[i].addr == bus.ID_ADDR1 && q[i].f == bus.ID_REG_TYPE[1]) hit = 1'b1;
         if (q[i].addr == bus.ID_ADDR2 && q[i].f == (bus.ID_REG_TYPE != 2'b00)) hit = 1'b1;
         if (bus.ID_REG_TYPE == 2'b11 && q[i].f && q[i].addr == bus.ID_ADDR3) hit = 1'b1;
         if (q[i].addr == bus.ID_DEST_ADDR && q[i].f == bus.ID_F_WRITE_EN) waw = 1'b1;
      end
      st = bus.ID_ISSUE && (hit || (req && (waw || q.size() == ENTRIES)));
      al = req && !st;
   endfunction

   task automatic drive(input logic iss, input logic [1:0] ty, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3, input logic we,
                        input logic fwe, input logic [4:0] dst, input logic [4:0] lat);
      bus.ID_ISSUE = iss;     bus.ID_REG_TYPE = ty;
      bus.ID_ADDR1 = a1;      bus.ID_ADDR2 = a2;      bus.ID_ADDR3 = a3;
      bus.ID_WRITE_EN = we;   bus.ID_F_WRITE_EN = fwe;
      bus.ID_DEST_ADDR = dst; bus.ID_LATENCY = lat;
   endtask

   // One ID cycle: drive, check at negedge, advance the model at posedge.
   task automatic step(input logic iss, input logic [1:0] ty, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input logic we,
                       input logic fwe, input logic [4:0] dst, input logic [4:0] lat,
                       output logic obs);
      logic st, al;
      drive(iss, ty, a1, a2, a3, we, fwe, dst, lat);
      @(negedge CLK);
      model_eval(st, al);
      obs = bus.STALL;
      chk("stall", {31'd0, bus.STALL}, {31'd0, st});
      chk("busy", {28'd0, bus.BUSY_COUNT}, q.size());
      if (int'(bus.BUSY_COUNT) > peak) peak = int'(bus.BUSY_COUNT);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("stall_cycles", bus.STALL_CYCLES, stat_m[31:0]);
`endif
      @(posedge CLK);
      if (al) q.push_back('{f: fwe, addr: dst, expire: cyc + int'(lat)});
      if (st && stat_m < 64'hFFFF_FFFF) stat_m++;
      cyc++;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].expire < cyc) q.delete(i);
      #1;
   endtask

   task automatic idle(input int n);
      logic s;
      for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, s);
   endtask

   // Hold one instruction in ID until it issues; returns stalled cycle count (bounded).
   task automatic until_go(input logic [1:0] ty, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] a3, input logic we, input logic fwe,
                           input logic [4:0] dst, input logic [4:0] lat, output int n);
      logic s;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         step(1, ty, a1, a2, a3, we, fwe, dst, lat, s);
         if (!s) break;
         n++;
      end
   endtask

   initial begin
      logic s;
      int   n;
      drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      #1 RESET = 1'b1;
      #2;
      chk("rst_stall", {31'd0, bus.STALL}, 0);
      chk("rst_busy", {28'd0, bus.BUSY_COUNT}, 0);
      @(negedge CLK) RESET = 1'b0;
      @(posedge CLK); #1;

      // load-use, L=1
      step(1, 2'b00, 0, 0, 0, 1, 0, 5'd5, 5'd1, s);
      until_go(2'b00, 5'd5, 5'd1, 0, 1, 0, 5'd6, 0, n);
      chk("load_use_stalls", n, 1);
      idle(3);

      // FDIV f3 L=10, FMADD reading f3 as op3 three cycles after
      step(1, 2'b00, 0, 0, 0, 0, 1, 5'd3, 5'd10, s);
      step(1, 2'b01, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, s);
      chk("op3_type01", {31'd0, s}, 0);
      idle(1);
      until_go(2'b11, 5'd1, 5'd2, 5'd3, 0, 1, 5'd4, 0, n);
      chk("fmadd_stalls", n, 8);
      idle(4);

      // int/float separation
      step(1, 2'b00, 0, 0, 0, 1, 0, 5'd7, 5'd4, s);
      step(1, 2'b10, 5'd7, 5'd7, 0, 0, 1, 5'd8, 0, s);
      chk("f7_vs_x7", {31'd0, s}, 0);
      step(1, 2'b00, 5'd7, 5'd1, 0, 1, 0, 5'd9, 0, s);
      chk("x7_read", {31'd0, s}, 1);
      idle(6);

      // x0 is never tracked
      step(1, 2'b00, 0, 0, 0, 1, 0, 5'd0, 5'd3, s);
      step(1, 2'b00, 5'd0, 5'd0, 0, 1, 0, 5'd2, 0, s);
      chk("x0_read", {31'd0, s}, 0);
      chk("x0_busy", {28'd0, bus.BUSY_COUNT}, 0);
      idle(2);

      // capacity, then WAW on a pending dest
      peak = 0;
      for (int i = 0; i < 4; i++) step(1, 2'b00, 0, 0, 0, 1, 0, 5'(10 + i), 5'd6, s);
      until_go(2'b00, 0, 0, 0, 1, 0, 5'd14, 5'd6, n);
      chk("full_stalls", n, 3);
      chk("busy_peak", peak, 4);
      until_go(2'b00, 0, 0, 0, 1, 0, 5'd14, 5'd6, n);
      chk("waw_stalls", n, 6);
      idle(14);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [4:0] lat;
         lat = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
         step(($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), 5'($urandom_range(0, 7)), lat, s);
      end
      idle(14);

      // async reset mid-countdown with three pending writes
      for (int i = 1; i <= 3; i++) step(1, 2'b00, 0, 0, 0, 1, 0, 5'(i), 5'd20, s);
      drive(1, 2'b00, 5'd1, 5'd2, 0, 0, 0, 0, 0);
      RESET = 1'b1;
      #1;
      chk("midrst_stall", {31'd0, bus.STALL}, 0);
      chk("midrst_busy", {28'd0, bus.BUSY_COUNT}, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("midrst_stats", bus.STALL_CYCLES, 0);
`endif
      q.delete();
      stat_m = 0;
      #1 RESET = 1'b0;
      step(1, 2'b00, 5'd1, 5'd2, 0, 0, 0, 0, 0, s);
      chk("post_rst_read", {31'd0, s}, 0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
